// File: rtl/snoop_pkg.sv
// Shared types, bus op codes, address keys and the result-combining helper
// used by the snoop responder and its per-agent models.
package snoop_pkg;

  typedef enum logic [1:0] {
    NOHIT = 2'b00,
    HIT   = 2'b01,
    HITM  = 2'b10
  } snoop_result_t;

  localparam logic [7:0] BUS_READ       = 8'd1;
  localparam logic [7:0] BUS_WRITE      = 8'd2;
  localparam logic [7:0] BUS_INVALIDATE = 8'd3;
  localparam logic [7:0] BUS_RWIM       = 8'd4;

  localparam logic [3:0] KEY_HIT_A  = 4'h2;
  localparam logic [3:0] KEY_HIT_B  = 4'h8;
  localparam logic [3:0] KEY_HITM_A = 4'h4;
  localparam logic [3:0] KEY_HITM_B = 4'hC;

  localparam int MAX_AGENTS = 8;
  localparam int MAX_VEC_W  = 2 * MAX_AGENTS;

  // Unused upper agent slots must be zero (NOHIT) so they never contribute.
  function automatic snoop_result_t combine(input logic [MAX_VEC_W-1:0] agents);
    logic any_hit;
    logic any_hitm;
    any_hit  = 1'b0;
    any_hitm = 1'b0;
    for (int i = 0; i < MAX_AGENTS; i++) begin
      if (agents[2*i +: 2] == HITM) any_hitm = 1'b1;
      if (agents[2*i +: 2] == HIT)  any_hit  = 1'b1;
    end
    if (any_hitm)     return HITM;
    else if (any_hit) return HIT;
    else              return NOHIT;
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Request/response handshake, statistics and clear for the snoop responder.
interface snoop_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_AGENTS = 2,
  parameter int CNT_WIDTH  = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [7:0]              req_op;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_result;
  logic [2*NUM_AGENTS-1:0] rsp_agent;
  logic [NUM_AGENTS-1:0]   rsp_hitm_mask;
  logic [CNT_WIDTH-1:0]    hit_count;
  logic [CNT_WIDTH-1:0]    hitm_count;
  logic                    multi_hitm_err;
  logic                    clear;

  modport slave (
    input  req_valid, req_addr, req_op, rsp_ready, clear,
    output req_ready, rsp_valid, rsp_result, rsp_agent, rsp_hitm_mask,
           hit_count, hitm_count, multi_hitm_err
  );

  modport master (
    output req_valid, req_addr, req_op, rsp_ready, clear,
    input  req_ready, rsp_valid, rsp_result, rsp_agent, rsp_hitm_mask,
           hit_count, hitm_count, multi_hitm_err
  );
endinterface

// File: rtl/snoop_agent_model.sv
// One modelled peer cache: maps its 4-bit address key and the bus op to a
// snoop result. Purely combinational.
module snoop_agent_model
  import snoop_pkg::*;
(
  input  logic [3:0]    key_i,
  input  logic [7:0]    op_i,
  output snoop_result_t result_o
);

  always_comb begin
    result_o = NOHIT;
    if (op_i == BUS_READ || op_i == BUS_RWIM) begin
      unique case (key_i)
        KEY_HIT_A, KEY_HIT_B:   result_o = HIT;
        KEY_HITM_A, KEY_HITM_B: result_o = HITM;
        default:                result_o = NOHIT;
      endcase
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// Pipelined snoop-result generator: per-agent results are computed at
// acceptance and travel LATENCY stages under a single global stall.
module snoop_responder
  import snoop_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_AGENTS = 2,
  parameter int LATENCY    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  snoop_responder_if.slave  bus
);

  localparam int VEC_W = 2 * NUM_AGENTS;

  snoop_result_t        agent_res [NUM_AGENTS];
  logic [VEC_W-1:0]     agent_vec;
  logic [LATENCY-1:0]   vld_q;
  logic [VEC_W-1:0]     agent_q [LATENCY];
  logic [NUM_AGENTS-1:0] hitm_mask;
  snoop_result_t        rsp_res;
  logic                 adv;
  logic                 rsp_hs;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] hitm_cnt_q, hitm_cnt_d;
  logic                 err_q, err_d;
  logic                 unused_addr;

  for (genvar i = 0; i < NUM_AGENTS; i++) begin : g_agent
    snoop_agent_model u_agent (
      .key_i    (bus.req_addr[4*i +: 4]),
      .op_i     (bus.req_op),
      .result_o (agent_res[i])
    );
    assign agent_vec[2*i +: 2] = agent_res[i];
  end

  assign unused_addr = ^bus.req_addr;

  assign adv    = !vld_q[LATENCY-1] || bus.rsp_ready;
  assign rsp_hs = vld_q[LATENCY-1] && bus.rsp_ready;

  // Bubbles carry zeroed agent data so idle outputs read as NOHIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) agent_q[i] <= '0;
    end else if (adv) begin
      vld_q[0]   <= bus.req_valid;
      agent_q[0] <= bus.req_valid ? agent_vec : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]   <= vld_q[i-1];
        agent_q[i] <= agent_q[i-1];
      end
    end
  end

  always_comb begin
    hitm_mask = '0;
    for (int i = 0; i < NUM_AGENTS; i++)
      hitm_mask[i] = (agent_q[LATENCY-1][2*i +: 2] == HITM);
  end

  assign rsp_res = combine(MAX_VEC_W'(agent_q[LATENCY-1]));

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    hitm_cnt_d = hitm_cnt_q;
    err_d      = err_q;
    if (bus.clear) begin
      hit_cnt_d  = '0;
      hitm_cnt_d = '0;
      err_d      = 1'b0;
    end else if (rsp_hs) begin
      if (rsp_res == HIT && hit_cnt_q != '1)   hit_cnt_d  = hit_cnt_q + 1'b1;
      if (rsp_res == HITM && hitm_cnt_q != '1) hitm_cnt_d = hitm_cnt_q + 1'b1;
      if ($countones(hitm_mask) > 1)           err_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      hitm_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      hitm_cnt_q <= hitm_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready      = adv;
  assign bus.rsp_valid      = vld_q[LATENCY-1];
  assign bus.rsp_result     = rsp_res;
  assign bus.rsp_agent      = agent_q[LATENCY-1];
  assign bus.rsp_hitm_mask  = hitm_mask;
  assign bus.hit_count      = hit_cnt_q;
  assign bus.hitm_count     = hitm_cnt_q;
  assign bus.multi_hitm_err = err_q;

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: expected results are queued at
// acceptance and compared at each response handshake.
module tb_snoop_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snoop_responder_if #(.ADDR_WIDTH(32), .NUM_AGENTS(2), .CNT_WIDTH(4)) bus ();

  snoop_responder #(
    .ADDR_WIDTH(32), .NUM_AGENTS(2), .LATENCY(2), .CNT_WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0] res;
    logic [3:0] agent;
    logic [1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   delivered = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_agent(input logic [3:0] k, input logic [7:0] op);
    if (op != 8'd1 && op != 8'd4) return 2'b00;
    if (k == 4'h2 || k == 4'h8) return 2'b01;
    if (k == 4'h4 || k == 4'hC) return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t ref_expect(input logic [31:0] addr, input logic [7:0] op);
    exp_t e;
    logic [1:0] a0, a1;
    a0 = ref_agent(addr[3:0], op);
    a1 = ref_agent(addr[7:4], op);
    e.agent = {a1, a0};
    e.mask  = {a1 == 2'b10, a0 == 2'b10};
    if (e.mask != 2'b00)                 e.res = 2'b10;
    else if (a0 == 2'b01 || a1 == 2'b01) e.res = 2'b01;
    else                                 e.res = 2'b00;
    return e;
  endfunction

  logic       stall_q = 1'b0;
  logic [7:0] held_q = '0;

  always @(negedge clk) begin : monitor
    logic [7:0] cur;
    exp_t e;
    cur = {bus.rsp_result, bus.rsp_agent, bus.rsp_hitm_mask};
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) check("rsp_stable", {24'b0, cur}, {24'b0, held_q});
      if (bus.req_valid && bus.req_ready)
        exp_q.push_back(ref_expect(bus.req_addr, bus.req_op));
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rsp_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", {24'b0, cur}, {24'b0, e});
          delivered++;
        end
      end
      stall_q <= bus.rsp_valid && !bus.rsp_ready;
      held_q  <= cur;
    end
  end

  task automatic send(input logic [31:0] addr, input logic [7:0] op);
    int n;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_op    = op;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", {31'b0, n < 50}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [31:0] stream_addr [5];
    stream_addr = '{32'h02, 32'h80, 32'h40, 32'h00, 32'h08};
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;
    bus.clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_result", {30'b0, bus.rsp_result}, 32'd0);
    check("rst_agent", {28'b0, bus.rsp_agent}, 32'd0);
    check("rst_mask", {30'b0, bus.rsp_hitm_mask}, 32'd0);
    check("rst_hit", {28'b0, bus.hit_count}, 32'd0);
    check("rst_hitm", {28'b0, bus.hitm_count}, 32'd0);
    check("rst_err", {31'b0, bus.multi_hitm_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h0000_0042, 8'd1);
    check("t1_lat_early", {31'b0, bus.rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_lat_valid", {31'b0, bus.rsp_valid}, 32'd1);
    check("t1_result", {30'b0, bus.rsp_result}, 32'h2);
    @(posedge clk);
    #1;
    check("t1_hitm_cnt", {28'b0, bus.hitm_count}, 32'd1);
    check("t1_hit_cnt", {28'b0, bus.hit_count}, 32'd0);

    send(32'h0000_00CC, 8'd2);
    drain();
    check("t2_hit_cnt", {28'b0, bus.hit_count}, 32'd0);
    check("t2_hitm_cnt", {28'b0, bus.hitm_count}, 32'd1);

    send(32'h0000_00C4, 8'd4);
    drain();
    check("t3_err", {31'b0, bus.multi_hitm_err}, 32'd1);
    check("t3_hitm_cnt", {28'b0, bus.hitm_count}, 32'd2);
    pulse_clear();
    check("t3_clr_err", {31'b0, bus.multi_hitm_err}, 32'd0);
    check("t3_clr_hit", {28'b0, bus.hit_count}, 32'd0);
    check("t3_clr_hitm", {28'b0, bus.hitm_count}, 32'd0);

    d0 = delivered;
    fork
      begin
        for (int i = 0; i < 5; i++) send(stream_addr[i], 8'd1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("t4_stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    drain();
    check("t4_delivered", delivered - d0, 32'd5);
    check("t4_hit_cnt", {28'b0, bus.hit_count}, 32'd3);
    check("t4_hitm_cnt", {28'b0, bus.hitm_count}, 32'd1);
    check("t4_err", {31'b0, bus.multi_hitm_err}, 32'd0);

    pulse_clear();
    for (int i = 0; i < 20; i++) send(32'h0000_0002, 8'd1);
    drain();
    check("t5_hit_sat", {28'b0, bus.hit_count}, 32'hF);
    check("t5_hitm_cnt", {28'b0, bus.hitm_count}, 32'd0);

    bus.rsp_ready = 1'b0;
    send(32'h0000_0002, 8'd1);
    send(32'h0000_0008, 8'd1);
    d0 = delivered;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("t6_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
      check("t6_req_ready", {31'b0, bus.req_ready}, 32'd1);
    end
    check("t6_delivered", delivered - d0, 32'd0);
    check("t6_hit_cnt", {28'b0, bus.hit_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
